esc_tx_ctrl: RTL and testbench
==============================

ESC_TX_CTRL -- requirements
Module: esc_tx_ctrl

Interface
REQ-001 SHALL have parameter TLPX, default 2, LP state hold time in TxClkEsc cycles, legal 1..15.
REQ-002 SHALL have ports:
- TxClkEsc  in  1  clock, all logic on rising edge.
- RstN  in  1  asynchronous active-low reset.
- TxRequestEsc  in  1  escape request from PPI.
- TxLpdtEsc  in  1  LPDT mode select.
- TxUlpsEsc  in  1  ULPS mode select.
- TxTriggerEsc  in  4  one-hot trigger select: bit0 reset-trigger, bit1..3 trigger1..3.
- TxDataEsc  in  8  LPDT byte from PPI.
- TxValidEsc  in  1  TxDataEsc valid.
- TxReadyEsc  out  1  one-cycle pulse, TxDataEsc accepted.
- EscSerEn  out  1  serializer enable.
- SerData  out  8  byte presented to serializer.
- Pause_Ready  out  1  high while in PAUSE.
- LpState  out  2  {Dp,Dn} line level when EscSerEn low.
- StopState  out  1  high in IDLE.
- UlpsActive  out  1  high in ULPS.

Function
REQ-003 SHALL implement states IDLE, E10, E00A, E01, E00B, CMD, DATA, PAUSE, ULPS, MARK.
REQ-004 SHALL drive LpState: IDLE 11, E10 10, E00A 00, E01 01, E00B 00, CMD/DATA 00, PAUSE 00, ULPS 00, MARK 10.
REQ-005 IDLE: on TxRequestEsc high, SHALL latch mode by priority LPDT > ULPS > lowest set trigger bit, go to E10; no mode selected -> stay IDLE.
REQ-006 E10, E00A, E01, E00B SHALL each last exactly TLPX cycles (4-bit hold counter), then advance in that order; E00B -> CMD.
REQ-007 TxRequestEsc SHALL be ignored from E10 through CMD; entry and command always complete.
REQ-008 CMD SHALL set SerData to command: LPDT 8'hE1, ULPS 8'h1E, reset-trigger 8'h62, trigger1 8'hA0, trigger2 8'h21, trigger3 8'h5D.
REQ-009 In CMD/DATA, EscSerEn SHALL be high; 3-bit slot counter SHALL count 0..7 and wrap; SerData SHALL be stable and valid in slot 0 of each byte.
REQ-010 At slot 7 of CMD: ULPS -> ULPS; trigger -> MARK; LPDT -> byte-continue rule REQ-011.
REQ-011 Byte-continue at slot 7: TxValidEsc high -> latch TxDataEsc into SerData, pulse TxReadyEsc same edge, enter/stay DATA at slot 0; else TxRequestEsc high -> PAUSE; else -> MARK.
REQ-012 PAUSE: EscSerEn low, slot counter held 0; TxValidEsc high -> latch byte, pulse TxReadyEsc, DATA slot 0; TxRequestEsc low (and TxValidEsc low) -> MARK; both high -> DATA wins.
REQ-013 ULPS: hold until TxRequestEsc low, then MARK.
REQ-014 MARK SHALL last TLPX cycles, then IDLE; new request sampled no earlier than first IDLE cycle.
REQ-015 TxReadyEsc SHALL pulse only with a byte latch; never two consecutive cycles.
REQ-016 EscSerEn SHALL deassert on the edge leaving slot 7 when next state is not DATA.

Reset
REQ-017 RstN low SHALL asynchronously force IDLE, counters 0, SerData 0, EscSerEn 0, TxReadyEsc 0, Pause_Ready 0, UlpsActive 0, LpState 11, StopState 1.
REQ-018 Reset mid-operation (any state) SHALL abandon the sequence; release returns to IDLE with no TxReadyEsc pulse.

Verification
REQ-019 TLPX=2, LPDT, TxValidEsc high with 8'hA5 then low, TxRequestEsc dropped after accept -> LpState 11,10,00,01,00 (2 cycles each), SerData E1 for 8 cycles, A5 for 8, MARK 10 for 2, IDLE; one TxReadyEsc pulse.
REQ-020 ULPS request held 20 cycles after command -> SerData 1E for 8 cycles, UlpsActive high until TxRequestEsc low, then LpState 10 for TLPX, then 11.
REQ-021 TxTriggerEsc=4'b0101 -> SerData 62 for 8 cycles, MARK, IDLE; no TxReadyEsc.
REQ-022 LPDT, TxValidEsc low at slot 7 of first data byte with request high -> PAUSE, Pause_Ready 1, EscSerEn 0; TxValidEsc high with 8'h3C -> DATA slot 0, SerData 3C, TxReadyEsc pulse.
REQ-023 Simultaneous TxLpdtEsc and TxUlpsEsc -> command E1.
REQ-024 RstN low during DATA slot 4 -> all outputs at reset values immediately; after release, IDLE, LpState 11.

Source files
------------

// File: rtl/esc_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : esc_tx_ctrl
// Brief    : MIPI D-PHY escape-mode transmit controller. Sequences the LP
//            escape entry, sends the command byte and then LPDT data,
//            triggers or ULPS, and ends with the mark-1 exit.
// Revision : 1.0 - initial release
// ============================================================================
module esc_tx_ctrl #(
  parameter int TLPX = 2
) (
  input  logic       TxClkEsc,
  input  logic       RstN,
  input  logic       TxRequestEsc,
  input  logic       TxLpdtEsc,
  input  logic       TxUlpsEsc,
  input  logic [3:0] TxTriggerEsc,
  input  logic [7:0] TxDataEsc,
  input  logic       TxValidEsc,
  output logic       TxReadyEsc,
  output logic       EscSerEn,
  output logic [7:0] SerData,
  output logic       Pause_Ready,
  output logic [1:0] LpState,
  output logic       StopState,
  output logic       UlpsActive
);

  localparam logic [3:0] c_ST_IDLE  = 4'd0;
  localparam logic [3:0] c_ST_E10   = 4'd1;
  localparam logic [3:0] c_ST_E00A  = 4'd2;
  localparam logic [3:0] c_ST_E01   = 4'd3;
  localparam logic [3:0] c_ST_E00B  = 4'd4;
  localparam logic [3:0] c_ST_CMD   = 4'd5;
  localparam logic [3:0] c_ST_DATA  = 4'd6;
  localparam logic [3:0] c_ST_PAUSE = 4'd7;
  localparam logic [3:0] c_ST_ULPS  = 4'd8;
  localparam logic [3:0] c_ST_MARK  = 4'd9;

  localparam logic [2:0] c_MODE_LPDT  = 3'd0;
  localparam logic [2:0] c_MODE_ULPS  = 3'd1;
  localparam logic [2:0] c_MODE_RTRIG = 3'd2;
  localparam logic [2:0] c_MODE_TRIG1 = 3'd3;
  localparam logic [2:0] c_MODE_TRIG2 = 3'd4;
  localparam logic [2:0] c_MODE_TRIG3 = 3'd5;

  // Last value of the hold counter in a TLPX-timed LP state
  localparam logic [3:0] c_HOLD_LAST = 4'(TLPX - 1);
  localparam logic [2:0] c_SLOT_LAST = 3'd7;

  logic [3:0] r_state;
  logic [3:0] w_nextState;
  logic [2:0] r_mode;
  logic [2:0] w_reqMode;
  logic       w_reqModeValid;
  logic [3:0] r_hold;
  logic       w_holdDone;
  logic       w_timedState;
  logic [2:0] r_slot;
  logic       w_slotLast;
  logic       w_serState;
  logic [7:0] r_serData;
  logic       r_txReady;
  logic       w_byteLatch;
  logic       w_cmdLoad;
  logic [7:0] w_cmdByte;

  assign w_timedState = (r_state == c_ST_E10)  || (r_state == c_ST_E00A) ||
                        (r_state == c_ST_E01)  || (r_state == c_ST_E00B) ||
                        (r_state == c_ST_MARK);
  assign w_holdDone   = (r_hold == c_HOLD_LAST);
  assign w_serState   = (r_state == c_ST_CMD) || (r_state == c_ST_DATA);
  assign w_slotLast   = (r_slot == c_SLOT_LAST);

  // A fresh byte is taken whenever DATA is entered at a byte boundary: from
  // slot 7 of CMD/DATA or straight out of PAUSE.
  assign w_byteLatch  = (w_nextState == c_ST_DATA) &&
                        ((r_state == c_ST_PAUSE) || (w_serState && w_slotLast));
  assign w_cmdLoad    = (r_state == c_ST_E00B) && (w_nextState == c_ST_CMD);

  // Requested mode by priority: LPDT, then ULPS, then lowest trigger bit
  always_comb begin
    w_reqModeValid = 1'b1;
    w_reqMode      = c_MODE_LPDT;
    if (TxLpdtEsc)            w_reqMode = c_MODE_LPDT;
    else if (TxUlpsEsc)       w_reqMode = c_MODE_ULPS;
    else if (TxTriggerEsc[0]) w_reqMode = c_MODE_RTRIG;
    else if (TxTriggerEsc[1]) w_reqMode = c_MODE_TRIG1;
    else if (TxTriggerEsc[2]) w_reqMode = c_MODE_TRIG2;
    else if (TxTriggerEsc[3]) w_reqMode = c_MODE_TRIG3;
    else                      w_reqModeValid = 1'b0;
  end

  // Command byte for the latched mode
  always_comb begin
    w_cmdByte = 8'hE1;
    case (r_mode)
      c_MODE_LPDT:  w_cmdByte = 8'hE1;
      c_MODE_ULPS:  w_cmdByte = 8'h1E;
      c_MODE_RTRIG: w_cmdByte = 8'h62;
      c_MODE_TRIG1: w_cmdByte = 8'hA0;
      c_MODE_TRIG2: w_cmdByte = 8'h21;
      c_MODE_TRIG3: w_cmdByte = 8'h5D;
      default:      w_cmdByte = 8'hE1;
    endcase
  end

  // State register
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) r_state <= c_ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic; the request line is not looked at from E10 through CMD
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_ST_IDLE:  if (TxRequestEsc && w_reqModeValid) w_nextState = c_ST_E10;
      c_ST_E10:   if (w_holdDone) w_nextState = c_ST_E00A;
      c_ST_E00A:  if (w_holdDone) w_nextState = c_ST_E01;
      c_ST_E01:   if (w_holdDone) w_nextState = c_ST_E00B;
      c_ST_E00B:  if (w_holdDone) w_nextState = c_ST_CMD;
      c_ST_CMD: begin
        if (w_slotLast) begin
          if (r_mode == c_MODE_ULPS)      w_nextState = c_ST_ULPS;
          else if (r_mode != c_MODE_LPDT) w_nextState = c_ST_MARK;
          else if (TxValidEsc)            w_nextState = c_ST_DATA;
          else if (TxRequestEsc)          w_nextState = c_ST_PAUSE;
          else                            w_nextState = c_ST_MARK;
        end
      end
      c_ST_DATA: begin
        if (w_slotLast) begin
          if (TxValidEsc)        w_nextState = c_ST_DATA;
          else if (TxRequestEsc) w_nextState = c_ST_PAUSE;
          else                   w_nextState = c_ST_MARK;
        end
      end
      c_ST_PAUSE: begin
        if (TxValidEsc)         w_nextState = c_ST_DATA;
        else if (!TxRequestEsc) w_nextState = c_ST_MARK;
      end
      c_ST_ULPS:  if (!TxRequestEsc) w_nextState = c_ST_MARK;
      c_ST_MARK:  if (w_holdDone) w_nextState = c_ST_IDLE;
      default:    w_nextState = c_ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    EscSerEn    = 1'b0;
    LpState     = 2'b00;
    StopState   = 1'b0;
    Pause_Ready = 1'b0;
    UlpsActive  = 1'b0;
    case (r_state)
      c_ST_IDLE:  begin LpState = 2'b11; StopState = 1'b1; end
      c_ST_E10:   LpState = 2'b10;
      c_ST_E01:   LpState = 2'b01;
      c_ST_CMD,
      c_ST_DATA:  EscSerEn = 1'b1;
      c_ST_PAUSE: Pause_Ready = 1'b1;
      c_ST_ULPS:  UlpsActive = 1'b1;
      c_ST_MARK:  LpState = 2'b10;
      default:    LpState = 2'b00;
    endcase
  end

  // Mode is captured once, on the request that starts the sequence
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) r_mode <= c_MODE_LPDT;
    else if ((r_state == c_ST_IDLE) && (w_nextState == c_ST_E10)) r_mode <= w_reqMode;
  end

  // Hold counter restarts at every state change, runs only in timed states
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) r_hold <= 4'd0;
    else if (w_timedState && (w_nextState == r_state)) r_hold <= r_hold + 4'd1;
    else r_hold <= 4'd0;
  end

  // Bit slot counter; wraps 7->0 so a byte boundary lines up with slot 0
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN)           r_slot <= 3'd0;
    else if (w_serState) r_slot <= r_slot + 3'd1;
    else                 r_slot <= 3'd0;
  end

  // Serializer byte: command on CMD entry, PPI data on each accepted byte
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN)            r_serData <= 8'h00;
    else if (w_cmdLoad)   r_serData <= w_cmdByte;
    else if (w_byteLatch) r_serData <= TxDataEsc;
  end

  // Ready pulse accompanies exactly the edge that captures a byte
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) r_txReady <= 1'b0;
    else       r_txReady <= w_byteLatch;
  end

  assign SerData    = r_serData;
  assign TxReadyEsc = r_txReady;

endmodule
`default_nettype wire

// File: tb/tb_esc_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_esc_tx_ctrl
// Brief    : Self-checking bench for esc_tx_ctrl. Output line activity is
//            compressed into runs of constant value and compared against a
//            queue of expected runs pushed by each stimulus scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esc_tx_ctrl;

  localparam int TLPX = 2;

  logic       TxClkEsc = 1'b0;
  logic       RstN = 1'b0;
  logic       TxRequestEsc = 1'b0;
  logic       TxLpdtEsc = 1'b0;
  logic       TxUlpsEsc = 1'b0;
  logic [3:0] TxTriggerEsc = 4'd0;
  logic [7:0] TxDataEsc = 8'd0;
  logic       TxValidEsc = 1'b0;
  logic       TxReadyEsc;
  logic       EscSerEn;
  logic [7:0] SerData;
  logic       Pause_Ready;
  logic [1:0] LpState;
  logic       StopState;
  logic       UlpsActive;

  esc_tx_ctrl #(.TLPX(TLPX)) dut (
    .TxClkEsc     (TxClkEsc),
    .RstN         (RstN),
    .TxRequestEsc (TxRequestEsc),
    .TxLpdtEsc    (TxLpdtEsc),
    .TxUlpsEsc    (TxUlpsEsc),
    .TxTriggerEsc (TxTriggerEsc),
    .TxDataEsc    (TxDataEsc),
    .TxValidEsc   (TxValidEsc),
    .TxReadyEsc   (TxReadyEsc),
    .EscSerEn     (EscSerEn),
    .SerData      (SerData),
    .Pause_Ready  (Pause_Ready),
    .LpState      (LpState),
    .StopState    (StopState),
    .UlpsActive   (UlpsActive)
  );

  always #5 TxClkEsc = ~TxClkEsc;

  int testCnt = 0;
  int failCnt = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run key: {stop, ulps, pause, serEn, lpState[1:0], serData (0 when serEn low)}
  typedef struct {
    logic [13:0] key;
    int          len;
    string       tag;
  } seg_t;

  seg_t sbQ[$];

  function automatic logic [13:0] mkKey(input logic stop, input logic ulps, input logic pause,
                                        input logic en, input logic [1:0] lp, input logic [7:0] data);
    return {stop, ulps, pause, en, lp, (en ? data : 8'h00)};
  endfunction

  task automatic pushSeg(input string tag, input logic [1:0] lp, input logic en,
                         input logic [7:0] data, input logic pause, input logic ulps, input int len);
    seg_t s;
    s.key = mkKey(1'b0, ulps, pause, en, lp, data);
    s.len = len;
    s.tag = tag;
    sbQ.push_back(s);
  endtask

  task automatic pushEntry();
    pushSeg("E10",  2'b10, 1'b0, 8'h00, 1'b0, 1'b0, TLPX);
    pushSeg("E00A", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, TLPX);
    pushSeg("E01",  2'b01, 1'b0, 8'h00, 1'b0, 1'b0, TLPX);
    pushSeg("E00B", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, TLPX);
  endtask

  task automatic pushByte(input string tag, input logic [7:0] data, input int len);
    pushSeg(tag, 2'b00, 1'b1, data, 1'b0, 1'b0, len);
  endtask

  task automatic pushMark();
    pushSeg("MARK", 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, TLPX);
  endtask

  // Monitor state
  logic        monEn = 1'b0;
  logic [13:0] runKey = 14'd0;
  logic [13:0] curKey;
  int          runLen = 0;
  int          readyCnt = 0;
  logic        prevReady = 1'b0;

  task automatic closeRun();
    seg_t s;
    if (!runKey[13]) begin
      checkEq("sb_run_expected", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        s = sbQ.pop_front();
        checkEq({s.tag, "_key"}, 32'(runKey), 32'(s.key));
        if (s.len > 0) checkEq({s.tag, "_len"}, runLen, s.len);
      end
    end
  endtask

  always @(negedge TxClkEsc) begin
    if (monEn) begin
      if (TxReadyEsc) begin
        readyCnt++;
        checkEq("ready_consec", 32'(prevReady), 32'd0);
      end
      prevReady = TxReadyEsc;
      curKey = mkKey(StopState, UlpsActive, Pause_Ready, EscSerEn, LpState, SerData);
      if (runLen > 0 && curKey == runKey) runLen++;
      else begin
        if (runLen > 0) closeRun();
        runKey = curKey;
        runLen = 1;
      end
    end
  end

  // sel: 0 ready, 1 pause, 2 ulps, 3 stop
  task automatic waitSig(input int sel, input string tag, input int maxCyc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < maxCyc && !hit; i++) begin
      @(negedge TxClkEsc);
      case (sel)
        0:       hit = TxReadyEsc;
        1:       hit = Pause_Ready;
        2:       hit = UlpsActive;
        default: hit = StopState;
      endcase
    end
    checkEq({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    waitSig(3, tag, 80);
    repeat (2) @(negedge TxClkEsc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] trigTab [4];
  logic [7:0] trigCmd [4];
  int         r0;

  initial begin
    trigTab[0] = 4'b0101; trigCmd[0] = 8'h62;
    trigTab[1] = 4'b1100; trigCmd[1] = 8'h21;
    trigTab[2] = 4'b1000; trigCmd[2] = 8'h5D;
    trigTab[3] = 4'b0010; trigCmd[3] = 8'hA0;

    // Reset values
    repeat (3) @(posedge TxClkEsc);
    #1;
    checkEq("rst_sersen", 32'(EscSerEn), 32'd0);
    checkEq("rst_serdata", 32'(SerData), 32'h00);
    checkEq("rst_ready", 32'(TxReadyEsc), 32'd0);
    checkEq("rst_pause", 32'(Pause_Ready), 32'd0);
    checkEq("rst_ulps", 32'(UlpsActive), 32'd0);
    checkEq("rst_lp", 32'(LpState), 32'h3);
    checkEq("rst_stop", 32'(StopState), 32'd1);
    @(negedge TxClkEsc);
    RstN = 1'b1;
    monEn = 1'b1;
    repeat (2) @(negedge TxClkEsc);

    // Request with no mode selected stays in IDLE
    TxRequestEsc = 1'b1;
    repeat (4) @(negedge TxClkEsc);
    checkEq("nomode_stop", 32'(StopState), 32'd1);
    checkEq("nomode_lp", 32'(LpState), 32'h3);
    TxRequestEsc = 1'b0;
    repeat (2) @(negedge TxClkEsc);

    // LPDT single byte
    pushEntry(); pushByte("CMD_E1", 8'hE1, 8); pushByte("DATA_A5", 8'hA5, 8); pushMark();
    r0 = readyCnt;
    TxLpdtEsc = 1'b1; TxRequestEsc = 1'b1; TxValidEsc = 1'b1; TxDataEsc = 8'hA5;
    waitSig(0, "lpdt_ready", 60);
    checkEq("lpdt_serdata", 32'(SerData), 32'hA5);
    TxValidEsc = 1'b0; TxRequestEsc = 1'b0; TxLpdtEsc = 1'b0; TxDataEsc = 8'h00;
    waitIdle("lpdt_idle");
    checkEq("lpdt_ready_cnt", readyCnt - r0, 1);

    // ULPS held for 20 cycles
    pushEntry(); pushByte("CMD_1E", 8'h1E, 8);
    pushSeg("ULPS", 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 21); pushMark();
    r0 = readyCnt;
    TxUlpsEsc = 1'b1; TxRequestEsc = 1'b1;
    waitSig(2, "ulps_enter", 60);
    repeat (20) @(posedge TxClkEsc);
    #1;
    checkEq("ulps_held", 32'(UlpsActive), 32'd1);
    TxRequestEsc = 1'b0; TxUlpsEsc = 1'b0;
    waitIdle("ulps_idle");
    checkEq("ulps_ready_cnt", readyCnt - r0, 0);

    // Triggers, lowest set bit wins
    for (int t = 0; t < 4; t++) begin
      pushEntry(); pushByte("CMD_TRIG", trigCmd[t], 8); pushMark();
      r0 = readyCnt;
      TxTriggerEsc = trigTab[t]; TxRequestEsc = 1'b1;
      @(negedge TxClkEsc);
      TxTriggerEsc = 4'd0; TxRequestEsc = 1'b0;
      waitIdle("trig_idle");
      checkEq("trig_ready_cnt", readyCnt - r0, 0);
    end

    // LPDT and ULPS together: LPDT wins; no data and request dropped -> MARK
    pushEntry(); pushByte("CMD_PRIO", 8'hE1, 8); pushMark();
    r0 = readyCnt;
    TxLpdtEsc = 1'b1; TxUlpsEsc = 1'b1; TxRequestEsc = 1'b1;
    @(negedge TxClkEsc);
    TxLpdtEsc = 1'b0; TxUlpsEsc = 1'b0; TxRequestEsc = 1'b0;
    waitIdle("prio_idle");
    checkEq("prio_ready_cnt", readyCnt - r0, 0);

    // PAUSE between bytes, then resume with 3C
    pushEntry(); pushByte("CMD_E1", 8'hE1, 8); pushByte("DATA_11", 8'h11, 8);
    pushSeg("PAUSE", 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 4);
    pushByte("DATA_3C", 8'h3C, 8); pushMark();
    r0 = readyCnt;
    TxLpdtEsc = 1'b1; TxRequestEsc = 1'b1; TxValidEsc = 1'b1; TxDataEsc = 8'h11;
    waitSig(0, "pause_ready1", 60);
    TxValidEsc = 1'b0; TxDataEsc = 8'h00;
    waitSig(1, "pause_enter", 20);
    checkEq("pause_sersen", 32'(EscSerEn), 32'd0);
    checkEq("pause_flag", 32'(Pause_Ready), 32'd1);
    repeat (3) @(posedge TxClkEsc);
    #1;
    TxValidEsc = 1'b1; TxDataEsc = 8'h3C;
    waitSig(0, "pause_ready2", 4);
    checkEq("resume_serdata", 32'(SerData), 32'h3C);
    checkEq("resume_sersen", 32'(EscSerEn), 32'd1);
    TxValidEsc = 1'b0; TxRequestEsc = 1'b0; TxLpdtEsc = 1'b0; TxDataEsc = 8'h00;
    waitIdle("pause_idle");
    checkEq("pause_ready_cnt", readyCnt - r0, 2);

    // Reset in DATA slot 4
    pushEntry(); pushByte("CMD_E1", 8'hE1, 8); pushByte("DATA_RST", 8'h5A, 4);
    TxLpdtEsc = 1'b1; TxRequestEsc = 1'b1; TxValidEsc = 1'b1; TxDataEsc = 8'h5A;
    waitSig(0, "rstmid_ready", 60);
    TxValidEsc = 1'b0; TxDataEsc = 8'h00;
    repeat (4) @(posedge TxClkEsc);
    #1;
    RstN = 1'b0;
    #1;
    checkEq("rstmid_sersen", 32'(EscSerEn), 32'd0);
    checkEq("rstmid_serdata", 32'(SerData), 32'h00);
    checkEq("rstmid_ready", 32'(TxReadyEsc), 32'd0);
    checkEq("rstmid_lp", 32'(LpState), 32'h3);
    checkEq("rstmid_stop", 32'(StopState), 32'd1);
    TxRequestEsc = 1'b0; TxLpdtEsc = 1'b0;
    repeat (2) @(negedge TxClkEsc);
    RstN = 1'b1;
    r0 = readyCnt;
    repeat (4) @(negedge TxClkEsc);
    checkEq("rstrel_stop", 32'(StopState), 32'd1);
    checkEq("rstrel_lp", 32'(LpState), 32'h3);
    checkEq("rstrel_ready_cnt", readyCnt - r0, 0);

    checkEq("sb_drained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
`default_nettype wire
